// File: rtl/spsram_ctrl.sv
// ---------------------------------------------------------------------------
// spsram_ctrl
//   Initiator-side controller for one single-port synchronous SRAM
//   (sync-read build). Converts a request stream (read/write) into
//   cen/wen/oen/addr/data strobes and returns read data on a response
//   stream. One access in flight at a time.
//
// Handshake rule (both streams): a transfer happens on the rising edge of
//   i_clk where valid and ready are both 1. A producer holds its payload
//   stable while valid is 1 and ready is 0; ready never depends on valid.
//
// Ports
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_req_valid / o_req_ready     request handshake
//   i_req_wr, i_req_addr,
//   i_req_wdata                   request payload (1 = write, 0 = read)
//   o_rsp_valid / i_rsp_ready     read response handshake
//   o_rsp_rdata                   read response payload
//   o_sram_cen/wen/oen/addr/wdata strobes to the SRAM
//   i_sram_rdata                  SRAM read data
//   o_init_done                   1 = controller open for requests
//
// Optional feature: define SPSRAM_CTRL_INIT_EN to fill the whole SRAM with
//   INIT_DATA after every reset before requests are accepted.
// ---------------------------------------------------------------------------
module spsram_ctrl #(
   parameter int                 BW_DATA   = 32,
   parameter int                 BW_ADDR   = 5,
   parameter logic [BW_DATA-1:0] INIT_DATA = '0
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_req_valid,
   output logic               o_req_ready,
   input  logic               i_req_wr,
   input  logic [BW_ADDR-1:0] i_req_addr,
   input  logic [BW_DATA-1:0] i_req_wdata,
   output logic               o_rsp_valid,
   input  logic               i_rsp_ready,
   output logic [BW_DATA-1:0] o_rsp_rdata,
   output logic               o_sram_cen,
   output logic               o_sram_wen,
   output logic               o_sram_oen,
   output logic [BW_ADDR-1:0] o_sram_addr,
   output logic [BW_DATA-1:0] o_sram_wdata,
   input  logic [BW_DATA-1:0] i_sram_rdata,
   output logic               o_init_done
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ACCESS = 3'd1,
      S_WAIT   = 3'd2,
      S_RESP   = 3'd3,
      S_INIT   = 3'd4
   } state_t;

`ifdef SPSRAM_CTRL_INIT_EN
   localparam state_t RESET_STATE = S_INIT;
`else
   localparam state_t RESET_STATE = S_IDLE;
`endif

   // state_q is the debug-visible FSM state
   state_t             state_q, state_d;
   logic               wr_q, wr_d;
   logic               cen_d, wen_d, oen_d;
   logic [BW_ADDR-1:0] addr_d;
   logic [BW_DATA-1:0] wdata_d;
   logic               rsp_valid_d;
   logic [BW_DATA-1:0] rsp_rdata_d;

`ifdef SPSRAM_CTRL_INIT_EN
   logic [BW_ADDR-1:0] init_cnt_q, init_cnt_d;
   logic               init_done_q, init_done_d;
`endif

   // Ready is a pure decode of the state register, never of i_req_valid
   assign o_req_ready = (state_q == S_IDLE);

   // ---------------- state and output registers ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= RESET_STATE;
         wr_q         <= 1'b0;
         o_sram_cen   <= 1'b0;
         o_sram_wen   <= 1'b0;
         o_sram_oen   <= 1'b0;
         o_sram_addr  <= '0;
         o_sram_wdata <= '0;
         o_rsp_valid  <= 1'b0;
         o_rsp_rdata  <= '0;
`ifdef SPSRAM_CTRL_INIT_EN
         init_cnt_q   <= '0;
         init_done_q  <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         wr_q         <= wr_d;
         o_sram_cen   <= cen_d;
         o_sram_wen   <= wen_d;
         o_sram_oen   <= oen_d;
         o_sram_addr  <= addr_d;
         o_sram_wdata <= wdata_d;
         o_rsp_valid  <= rsp_valid_d;
         o_rsp_rdata  <= rsp_rdata_d;
`ifdef SPSRAM_CTRL_INIT_EN
         init_cnt_q   <= init_cnt_d;
         init_done_q  <= init_done_d;
`endif
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (i_req_valid) state_d = S_ACCESS;
         S_ACCESS: state_d = wr_q ? S_IDLE : S_WAIT;
         S_WAIT:   state_d = S_RESP;
         S_RESP:   if (i_rsp_ready) state_d = S_IDLE;
`ifdef SPSRAM_CTRL_INIT_EN
         S_INIT:   if (init_cnt_q == {BW_ADDR{1'b1}}) state_d = S_IDLE;
`endif
         default:  state_d = S_IDLE;
      endcase
   end

   // ---------------- next-output logic ----------------
   // Strobes default to 0 so they are high for exactly one cycle per access;
   // address/data and the response payload hold their last value.
   always_comb begin
      wr_d        = wr_q;
      cen_d       = 1'b0;
      wen_d       = 1'b0;
      oen_d       = 1'b0;
      addr_d      = o_sram_addr;
      wdata_d     = o_sram_wdata;
      rsp_valid_d = o_rsp_valid;
      rsp_rdata_d = o_rsp_rdata;
`ifdef SPSRAM_CTRL_INIT_EN
      init_cnt_d  = init_cnt_q;
      init_done_d = init_done_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (i_req_valid) begin
               wr_d    = i_req_wr;
               cen_d   = 1'b1;
               wen_d   = i_req_wr;
               oen_d   = ~i_req_wr;
               addr_d  = i_req_addr;
               wdata_d = i_req_wdata;
            end
         end
         S_WAIT: begin
            // The SRAM presents read data during this cycle only
            rsp_rdata_d = i_sram_rdata;
            rsp_valid_d = 1'b1;
         end
         S_RESP: begin
            if (i_rsp_ready) rsp_valid_d = 1'b0;
         end
`ifdef SPSRAM_CTRL_INIT_EN
         S_INIT: begin
            // One write per cycle; the strobe for address k is on the bus
            // the cycle after the counter holds k.
            cen_d      = 1'b1;
            wen_d      = 1'b1;
            addr_d     = init_cnt_q;
            wdata_d    = INIT_DATA;
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == {BW_ADDR{1'b1}}) init_done_d = 1'b1;
         end
`endif
         default: ;
      endcase
   end

`ifdef SPSRAM_CTRL_INIT_EN
   assign o_init_done = init_done_q;
`else
   assign o_init_done = 1'b1;
`endif

endmodule

// File: tb/tb_spsram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spsram_ctrl
//   Directed bench for spsram_ctrl with a behavioural sync-read SRAM.
//   Table of transactions plus hand-written cycle-level sequences.
// ---------------------------------------------------------------------------
module tb_spsram_ctrl;

   localparam int BW_DATA = 32;
   localparam int BW_ADDR = 5;
   localparam logic [BW_DATA-1:0] INIT_VAL = 32'hA5A5A5A5;

   // ---------------- clock / reset ----------------
   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   always #5 i_clk = ~i_clk;

   logic               i_req_valid = 1'b0;
   logic               o_req_ready;
   logic               i_req_wr = 1'b0;
   logic [BW_ADDR-1:0] i_req_addr = '0;
   logic [BW_DATA-1:0] i_req_wdata = '0;
   logic               o_rsp_valid;
   logic               i_rsp_ready = 1'b0;
   logic [BW_DATA-1:0] o_rsp_rdata;
   logic               o_sram_cen, o_sram_wen, o_sram_oen;
   logic [BW_ADDR-1:0] o_sram_addr;
   logic [BW_DATA-1:0] o_sram_wdata;
   logic [BW_DATA-1:0] i_sram_rdata;
   logic               o_init_done;

   spsram_ctrl #(
      .BW_DATA  (BW_DATA),
      .BW_ADDR  (BW_ADDR),
      .INIT_DATA(INIT_VAL)
   ) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_req_valid (i_req_valid),
      .o_req_ready (o_req_ready),
      .i_req_wr    (i_req_wr),
      .i_req_addr  (i_req_addr),
      .i_req_wdata (i_req_wdata),
      .o_rsp_valid (o_rsp_valid),
      .i_rsp_ready (i_rsp_ready),
      .o_rsp_rdata (o_rsp_rdata),
      .o_sram_cen  (o_sram_cen),
      .o_sram_wen  (o_sram_wen),
      .o_sram_oen  (o_sram_oen),
      .o_sram_addr (o_sram_addr),
      .o_sram_wdata(o_sram_wdata),
      .i_sram_rdata(i_sram_rdata),
      .o_init_done (o_init_done)
   );

   // ---------------- sync-read SRAM model ----------------
   // Read data registered at the access edge; output enable is registered
   // alongside it so data is driven only in the cycle after a read access.
   logic [BW_DATA-1:0] mem [2**BW_ADDR];
   logic [BW_DATA-1:0] sram_dout = '0;
   logic               sram_oe_q = 1'b0;
   always @(posedge i_clk) begin
      sram_oe_q <= o_sram_cen & ~o_sram_wen & o_sram_oen;
      if (o_sram_cen) begin
         if (o_sram_wen) mem[o_sram_addr] <= o_sram_wdata;
         else            sram_dout <= mem[o_sram_addr];
      end
   end
   assign i_sram_rdata = sram_oe_q ? sram_dout : 'z;

   // ---------------- scoreboard ----------------
   int n_chk  = 0;
   int n_fail = 0;
   logic [BW_DATA-1:0] exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks (all act on the falling edge) ----------------
   task automatic wait_ready();
      int t = 0;
      while (!o_req_ready && t < 100) begin
         @(negedge i_clk);
         t++;
      end
      chk("req_ready_timeout", 64'(t < 100), 64'd1);
   endtask

   task automatic do_write(input logic [BW_ADDR-1:0] a, input logic [BW_DATA-1:0] d);
      wait_ready();
      i_req_valid = 1'b1; i_req_wr = 1'b1; i_req_addr = a; i_req_wdata = d;
      @(negedge i_clk);
      i_req_valid = 1'b0;
   endtask

   // Issue a read, wait for its response, compare against the scoreboard,
   // then hold off rsp_ready for a random number of cycles.
   task automatic do_read(input logic [BW_ADDR-1:0] a);
      int t = 0;
      logic [BW_DATA-1:0] e;
      wait_ready();
      i_req_valid = 1'b1; i_req_wr = 1'b0; i_req_addr = a;
      @(negedge i_clk);
      i_req_valid = 1'b0;
      while (!o_rsp_valid && t < 20) begin
         @(negedge i_clk);
         t++;
      end
      chk("rsp_timeout", 64'(t < 20), 64'd1);
      e = exp_q.pop_front();
      chk($sformatf("rdata_addr%0d", a), 64'(o_rsp_rdata), 64'(e));
      repeat ($urandom_range(0, 2)) @(negedge i_clk);
      i_rsp_ready = 1'b1;
      @(negedge i_clk);
      i_rsp_ready = 1'b0;
   endtask

`ifdef SPSRAM_CTRL_INIT_EN
   // Follow the init sweep: every strobe cycle must carry the next address.
   task automatic check_init_sweep();
      int k = 0;
      int t = 0;
      while (!o_init_done && t < 100) begin
         if (o_sram_cen) begin
            chk("init_addr", 64'(o_sram_addr), 64'(k));
            chk("init_wen",  64'(o_sram_wen), 64'd1);
            chk("init_data", 64'(o_sram_wdata), 64'(INIT_VAL));
            k++;
         end
         chk("init_req_ready", 64'(o_req_ready), 64'd0);
         @(negedge i_clk);
         t++;
      end
      // final write (addr 31) is on the bus together with init_done
      chk("init_last_cen",  64'(o_sram_cen), 64'd1);
      chk("init_last_addr", 64'(o_sram_addr), 64'd31);
      chk("init_writes", 64'(k + 1), 64'd32);
      chk("init_done", 64'(o_init_done), 64'd1);
   endtask
`endif

   // ---------------- transaction table ----------------
   typedef struct {
      logic               wr;
      logic [BW_ADDR-1:0] addr;
      logic [BW_DATA-1:0] data;   // write data, or expected read data
   } vec_t;

   vec_t vecs[10];

   localparam logic EXP_READY_IN_RESET =
`ifdef SPSRAM_CTRL_INIT_EN
      1'b0;
`else
      1'b1;
`endif

   initial begin
      bit saw_rsp;

      // reset state (rst held across two edges)
      @(negedge i_clk); @(negedge i_clk);
      chk("rst_cen",       64'(o_sram_cen), 64'd0);
      chk("rst_wen",       64'(o_sram_wen), 64'd0);
      chk("rst_oen",       64'(o_sram_oen), 64'd0);
      chk("rst_addr",      64'(o_sram_addr), 64'd0);
      chk("rst_wdata",     64'(o_sram_wdata), 64'd0);
      chk("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
      chk("rst_rsp_rdata", 64'(o_rsp_rdata), 64'd0);
      chk("rst_req_ready", 64'(o_req_ready), 64'(EXP_READY_IN_RESET));
      chk("rst_init_done", 64'(o_init_done), 64'(EXP_READY_IN_RESET));
      i_rst = 1'b0;

`ifdef SPSRAM_CTRL_INIT_EN
      @(negedge i_clk);
      check_init_sweep();
      @(negedge i_clk);
      exp_q.push_back(INIT_VAL);
      do_read(5'd17);
`endif

      // Test 1: write addr 3
      chk("t1_ready_before", 64'(o_req_ready), 64'd1);
      i_req_valid = 1'b1; i_req_wr = 1'b1; i_req_addr = 5'd3; i_req_wdata = 32'hDEADBEEF;
      @(negedge i_clk);
      i_req_valid = 1'b0;
      chk("t1_cen",   64'(o_sram_cen), 64'd1);
      chk("t1_wen",   64'(o_sram_wen), 64'd1);
      chk("t1_oen",   64'(o_sram_oen), 64'd0);
      chk("t1_addr",  64'(o_sram_addr), 64'd3);
      chk("t1_wdata", 64'(o_sram_wdata), 64'hDEADBEEF);
      chk("t1_ready_busy", 64'(o_req_ready), 64'd0);
      @(negedge i_clk);
      chk("t1_ready_after", 64'(o_req_ready), 64'd1);
      chk("t1_cen_drop",    64'(o_sram_cen), 64'd0);

      // Test 2: read addr 3, cycle by cycle
      i_req_valid = 1'b1; i_req_wr = 1'b0; i_req_addr = 5'd3;
      @(negedge i_clk);                       // ACCESS
      i_req_valid = 1'b0;
      chk("t2_cen",  64'(o_sram_cen), 64'd1);
      chk("t2_wen",  64'(o_sram_wen), 64'd0);
      chk("t2_oen",  64'(o_sram_oen), 64'd1);
      chk("t2_addr", 64'(o_sram_addr), 64'd3);
      chk("t2_valid_n1", 64'(o_rsp_valid), 64'd0);
      @(negedge i_clk);                       // WAIT
      chk("t2_cen_drop", 64'(o_sram_cen), 64'd0);
      chk("t2_oen_drop", 64'(o_sram_oen), 64'd0);
      chk("t2_valid_n2", 64'(o_rsp_valid), 64'd0);
      @(negedge i_clk);                       // RESP
      chk("t2_valid", 64'(o_rsp_valid), 64'd1);
      chk("t2_rdata", 64'(o_rsp_rdata), 64'hDEADBEEF);
      i_rsp_ready = 1'b1;
      @(negedge i_clk);
      i_rsp_ready = 1'b0;
      chk("t2_valid_clr", 64'(o_rsp_valid), 64'd0);
      chk("t2_ready_back", 64'(o_req_ready), 64'd1);

      // Test 3: response backpressure for 5 cycles
      i_req_valid = 1'b1; i_req_wr = 1'b0; i_req_addr = 5'd3;
      @(negedge i_clk);
      i_req_valid = 1'b0;
      @(negedge i_clk); @(negedge i_clk);
      for (int i = 0; i < 5; i++) begin
         chk("t3_hold_valid", 64'(o_rsp_valid), 64'd1);
         chk("t3_hold_rdata", 64'(o_rsp_rdata), 64'hDEADBEEF);
         chk("t3_hold_ready", 64'(o_req_ready), 64'd0);
         @(negedge i_clk);
      end
      i_rsp_ready = 1'b1;
      @(negedge i_clk);
      i_rsp_ready = 1'b0;
      chk("t3_valid_clr", 64'(o_rsp_valid), 64'd0);
      chk("t3_ready_back", 64'(o_req_ready), 64'd1);

      // Test 4 + table: boundary addresses and overwrites
      vecs[0] = '{1'b1, 5'd0,  32'h00000001};
      vecs[1] = '{1'b1, 5'd31, 32'h00000002};
      vecs[2] = '{1'b0, 5'd0,  32'h00000001};
      vecs[3] = '{1'b0, 5'd31, 32'h00000002};
      vecs[4] = '{1'b1, 5'd17, 32'h12345678};
      vecs[5] = '{1'b0, 5'd17, 32'h12345678};
      vecs[6] = '{1'b1, 5'd31, 32'hCAFEF00D};
      vecs[7] = '{1'b0, 5'd31, 32'hCAFEF00D};
      vecs[8] = '{1'b0, 5'd0,  32'h00000001};
      vecs[9] = '{1'b0, 5'd3,  32'hDEADBEEF};
      for (int i = 0; i < 10; i++) begin
         if (vecs[i].wr) begin
            do_write(vecs[i].addr, vecs[i].data);
         end else begin
            exp_q.push_back(vecs[i].data);
            do_read(vecs[i].addr);
         end
      end

      // Test 5: reset while a read is in WAIT
      wait_ready();
      i_req_valid = 1'b1; i_req_wr = 1'b0; i_req_addr = 5'd0;
      @(negedge i_clk);                       // ACCESS
      i_req_valid = 1'b0;
      @(negedge i_clk);                       // WAIT
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      chk("t5_cen",   64'(o_sram_cen), 64'd0);
      chk("t5_oen",   64'(o_sram_oen), 64'd0);
      chk("t5_wen",   64'(o_sram_wen), 64'd0);
      chk("t5_valid", 64'(o_rsp_valid), 64'd0);
      chk("t5_ready", 64'(o_req_ready), 64'(EXP_READY_IN_RESET));
      saw_rsp = 1'b0;
      i_rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge i_clk);
         if (o_rsp_valid) saw_rsp = 1'b1;
      end
      i_rsp_ready = 1'b0;
      chk("t5_no_rsp", 64'(saw_rsp), 64'd0);

`ifdef SPSRAM_CTRL_INIT_EN
      wait_ready();
      exp_q.push_back(INIT_VAL);
      do_read(5'd17);
`else
      exp_q.push_back(32'hCAFEF00D);
      do_read(5'd31);
`endif

      chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
